reg_mux_adapt: RTL and testbench
================================

Name: reg_mux_adapt

Overview:
- Parametrised registered N-channel selector with width adaptation and a valid/ready output stage.
- Picks one of N_CH equal-width input channels and resizes the value to OUT_W:
  - truncates to the low bits when narrowing;
  - zero- or sign-extends when widening.
- Registers the result through a 2-entry skid stage, so full throughput is kept under backpressure.
- Successor to the fixed-width clocked select-and-truncate register.
- Adds parametrised channel count and widths, signed mode, handshaking, and a sticky lossy-truncation flag.

Parameters:
- N_CH, 2, number of input channels (>=2).
- IN_W, 8, width of each input channel.
- OUT_W, 6, output width; may be less than, equal to, or greater than IN_W.
- SIGNED, 0, 0 = zero-extend / unsigned loss check; 1 = sign-extend / signed loss check.
- SEL_W, $clog2(N_CH), width of sel.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_data  input  N_CH*IN_W  channel k occupies bits [k*IN_W +: IN_W]
- in_valid  input  1  source has data
- in_ready  output  1  block can accept
- sel  input  SEL_W  channel index, sampled with the transfer
- out_data  output  OUT_W  registered adapted value
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts
- trunc_seen  output  1  sticky: an accepted word lost information
- trunc_clr  input  1  synchronous clear of trunc_seen

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, skid empty, trunc_seen=0, in_ready=1 during and after reset.
- Accept: an input transfer occurs when in_valid && in_ready. The word is adapt(in_data[sel]), computed from sel at that edge.
- Out-of-range sel (sel >= N_CH): adapted word is all-zero; loss flag is not set.
- adapt(), OUT_W < IN_W: result = low OUT_W bits. Lossy when:
  - SIGNED=0: any discarded bit is 1;
  - SIGNED=1: discarded bits are not all equal to bit OUT_W-1.
- adapt(), OUT_W >= IN_W: zero-extend (SIGNED=0) or sign-extend (SIGNED=1); never lossy.
- Latency: an accept into an empty block gives out_valid=1 with that word on the next cycle.
- Output transfer occurs when out_valid && out_ready. out_data must stay stable while out_valid && !out_ready.
- States:
  - EMPTY: out_valid=0, in_ready=1.
    - accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - accept with no drain -> TWO; the new word goes to skid.
    - drain with no accept -> EMPTY.
    - drain and accept together -> ONE; the new word loads the output register.
  - TWO: out_valid=1, in_ready=0.
    - drain -> ONE; skid moves to the output register.
- Ordering: strict FIFO order; no word is dropped or duplicated.
- trunc_seen:
  - set on the edge after any accept whose word is lossy;
  - cleared by trunc_clr;
  - if set and clear occur in the same cycle, set wins;
  - stays independent of draining.
- Reset mid-operation: pending words are discarded, all state goes to reset values, and no out_valid glitch occurs after release.

Optional Feature:
- Macro: REG_MUX_ADAPT_SATURATE_EN.
- Defined: when narrowing and the word is lossy, the output saturates instead of truncating.
  - SIGNED=0: output is all-ones.
  - SIGNED=1: output is the most-positive value (0 followed by ones) or the most-negative value (1 followed by zeros), chosen by the input MSB.
  - trunc_seen is still set.
- Not defined: plain truncation as above; no saturation logic is built.

Test Plan:
- N_CH=2, IN_W=8, OUT_W=6, SIGNED=0; ch0=0xAA, ch1=0xBB, out_ready=1:
  - sel=0 accept -> next cycle out_data=0x2A, out_valid=1, trunc_seen=1;
  - trunc_clr, then sel=1 -> out_data=0x3B, trunc_seen=1.
- Same config, ch0=0x15 -> out_data=0x15, trunc_seen stays 0.
- Backpressure: out_ready=0, accept 0x01, then 0x02:
  - third beat sees in_ready=0;
  - raise out_ready -> 0x01, 0x02, 0x03 drain in order;
  - no beat is lost or repeated.
- SIGNED=1, IN_W=8, OUT_W=10: input 0x85 -> out_data=0x385. SIGNED=1, OUT_W=6: input 0xF5 -> 0x35, trunc_seen=0.
- Reset mid-operation:
  - fill both entries, assert rst between clock edges;
  - out_valid=0, out_data=0, trunc_seen=0 immediately;
  - after release, in_ready=1 and no stale words appear.
- With REG_MUX_ADAPT_SATURATE_EN, OUT_W=6:
  - SIGNED=0, 0xAA -> 0x3F;
  - SIGNED=1, 0x85 -> 0x20 and 0x7F -> 0x1F;
  - trunc_seen=1 in every case.

Source files
------------

// File: rtl/reg_mux_adapt.sv
// reg_mux_adapt: registered N-channel select, resize and 2-entry skid output.
// Optional: REG_MUX_ADAPT_SATURATE_EN saturates lossy narrowed words.
module reg_mux_adapt #(
  parameter int N_CH   = 2,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 6,
  parameter int SIGNED = 0,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*IN_W-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   trunc_seen,
  input  logic                   trunc_clr
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] r_skid;
  logic             r_trunc;

  logic [IN_W-1:0]  w_ch;
  logic [OUT_W-1:0] w_adapt;
  logic             w_lossy;
  logic             w_acc;
  logic             w_drn;
  logic             w_ld_out;
  logic             w_mv_skid;
  logic             w_ld_skid;

  // Out-of-range sel matches no channel and yields zero, which is never lossy.
  always_comb begin
    w_ch = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        w_ch = in_data[k*IN_W +: IN_W];
      end
    end
  end

  if (OUT_W < IN_W) begin : g_narrow
    logic [IN_W-OUT_W-1:0] w_disc;
    logic [OUT_W-1:0]      w_trunc;
    assign w_disc  = w_ch[IN_W-1:OUT_W];
    assign w_trunc = w_ch[OUT_W-1:0];
    assign w_lossy = (SIGNED != 0)
      ? (w_disc != {(IN_W-OUT_W){w_ch[OUT_W-1]}})
      : (|w_disc);
`ifdef REG_MUX_ADAPT_SATURATE_EN
    logic [OUT_W-1:0] w_sat;
    always_comb begin
      w_sat = '1;
      if (SIGNED != 0) begin
        w_sat = w_ch[IN_W-1]
          ? {1'b1, {(OUT_W-1){1'b0}}}
          : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
    assign w_adapt = w_lossy ? w_sat : w_trunc;
`else
    assign w_adapt = w_trunc;
`endif
  end else begin : g_wide
    assign w_adapt = (SIGNED != 0)
      ? OUT_W'($signed(w_ch))
      : OUT_W'(w_ch);
    assign w_lossy = 1'b0;
  end

  assign in_ready   = (r_state != TWO);
  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_out;
  assign trunc_seen = r_trunc;

  assign w_acc = in_valid && in_ready;
  assign w_drn = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_ld_out  = 1'b0;
    w_mv_skid = 1'b0;
    w_ld_skid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_next   = ONE;
          w_ld_out = 1'b1;
        end
      end
      ONE: begin
        if (w_acc && !w_drn) begin
          w_next    = TWO;
          w_ld_skid = 1'b1;
        end else if (!w_acc && w_drn) begin
          w_next = EMPTY;
        end else if (w_acc && w_drn) begin
          w_ld_out = 1'b1;
        end
      end
      TWO: begin
        if (w_drn) begin
          w_next    = ONE;
          w_mv_skid = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_out) begin
        r_out <= w_adapt;
      end else if (w_mv_skid) begin
        r_out <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_adapt;
      end
    end
  end

  // A lossy accept in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trunc <= 1'b0;
    end else if (w_acc && w_lossy) begin
      r_trunc <= 1'b1;
    end else if (trunc_clr) begin
      r_trunc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_mux_adapt.sv
// Directed self-checking bench for reg_mux_adapt across several configs.
module tb_reg_mux_adapt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

`ifdef REG_MUX_ADAPT_SATURATE_EN
  localparam logic [5:0] E_AA   = 6'h3F;
  localparam logic [5:0] E_BB   = 6'h3F;
  localparam logic [5:0] E_S85  = 6'h20;
  localparam logic [5:0] E_S7F  = 6'h1F;
`else
  localparam logic [5:0] E_AA   = 6'h2A;
  localparam logic [5:0] E_BB   = 6'h3B;
  localparam logic [5:0] E_S85  = 6'h05;
  localparam logic [5:0] E_S7F  = 6'h3F;
`endif

  // u0: N_CH=2, IN_W=8, OUT_W=6, unsigned
  logic [15:0] d0 = '0;
  logic        v0 = 1'b0;
  logic        r0;
  logic        s0 = 1'b0;
  logic [5:0]  od0;
  logic        ov0;
  logic        or0 = 1'b1;
  logic        t0;
  logic        c0 = 1'b0;

  // u1: signed widening to 10
  logic [15:0] d1 = '0;
  logic        v1 = 1'b0;
  logic        r1;
  logic [9:0]  od1;
  logic        ov1;
  logic        t1;

  // u2: signed narrowing to 6
  logic [15:0] d2 = '0;
  logic        v2 = 1'b0;
  logic        r2;
  logic [5:0]  od2;
  logic        ov2;
  logic        t2;

  // u3: 3 channels, sel may be out of range
  logic [23:0] d3 = '0;
  logic        v3 = 1'b0;
  logic        r3;
  logic [1:0]  s3 = 2'd0;
  logic [5:0]  od3;
  logic        ov3;
  logic        t3;

  reg_mux_adapt #(
    .N_CH(2), .IN_W(8), .OUT_W(6), .SIGNED(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .in_data(d0), .in_valid(v0), .in_ready(r0),
    .sel(s0),
    .out_data(od0), .out_valid(ov0), .out_ready(or0),
    .trunc_seen(t0), .trunc_clr(c0)
  );

  reg_mux_adapt #(
    .N_CH(2), .IN_W(8), .OUT_W(10), .SIGNED(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .in_data(d1), .in_valid(v1), .in_ready(r1),
    .sel(1'b0),
    .out_data(od1), .out_valid(ov1), .out_ready(1'b1),
    .trunc_seen(t1), .trunc_clr(1'b0)
  );

  reg_mux_adapt #(
    .N_CH(2), .IN_W(8), .OUT_W(6), .SIGNED(1)
  ) u2 (
    .clk(clk), .rst(rst),
    .in_data(d2), .in_valid(v2), .in_ready(r2),
    .sel(1'b1),
    .out_data(od2), .out_valid(ov2), .out_ready(1'b1),
    .trunc_seen(t2), .trunc_clr(1'b0)
  );

  reg_mux_adapt #(
    .N_CH(3), .IN_W(8), .OUT_W(6), .SIGNED(0)
  ) u3 (
    .clk(clk), .rst(rst),
    .in_data(d3), .in_valid(v3), .in_ready(r3),
    .sel(s3),
    .out_data(od3), .out_valid(ov3), .out_ready(1'b1),
    .trunc_seen(t3), .trunc_clr(1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (ov0 !== 1'b0 || od0 !== 6'h00 || t0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during got v=%b d=%h t=%b exp 0 00 0",
               ov0, od0, t0);
    end
    n_chk++;
    if (r0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b exp 1", r0);
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_chk++;
    if (ov0 !== 1'b0 || r0 !== 1'b1 || t0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after got v=%b r=%b t=%b exp 0 1 0",
               ov0, r0, t0);
    end
  endtask

  task automatic test_basic();
    d0  = {8'hBB, 8'hAA};
    s0  = 1'b0;
    or0 = 1'b1;
    v0  = 1'b1;
    tick();
    v0 = 1'b0;
    n_chk++;
    if (ov0 !== 1'b1 || od0 !== E_AA || t0 !== 1'b1) begin
      n_fail++;
      $display("FAIL sel0 got v=%b d=%h t=%b exp 1 %h 1",
               ov0, od0, t0, E_AA);
    end
    c0 = 1'b1;
    tick();
    c0 = 1'b0;
    n_chk++;
    if (t0 !== 1'b0 || ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr got t=%b v=%b exp 0 0", t0, ov0);
    end
    s0 = 1'b1;
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    n_chk++;
    if (ov0 !== 1'b1 || od0 !== E_BB || t0 !== 1'b1) begin
      n_fail++;
      $display("FAIL sel1 got v=%b d=%h t=%b exp 1 %h 1",
               ov0, od0, t0, E_BB);
    end
    c0 = 1'b1;
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    c0 = 1'b0;
    n_chk++;
    if (t0 !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins got %b exp 1", t0);
    end
    c0 = 1'b1;
    tick();
    c0 = 1'b0;
    n_chk++;
    if (t0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr2 got %b exp 0", t0);
    end
  endtask

  task automatic test_noloss();
    d0 = {8'hBB, 8'h15};
    s0 = 1'b0;
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    n_chk++;
    if (ov0 !== 1'b1 || od0 !== 6'h15 || t0 !== 1'b0) begin
      n_fail++;
      $display("FAIL noloss got v=%b d=%h t=%b exp 1 15 0",
               ov0, od0, t0);
    end
    tick();
  endtask

  task automatic test_signed();
    d1 = {8'h00, 8'h85};
    v1 = 1'b1;
    d2 = {8'hF5, 8'h00};
    v2 = 1'b1;
    tick();
    v1 = 1'b0;
    v2 = 1'b0;
    n_chk++;
    if (ov1 !== 1'b1 || od1 !== 10'h385 || t1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sext got v=%b d=%h t=%b exp 1 385 0",
               ov1, od1, t1);
    end
    n_chk++;
    if (ov2 !== 1'b1 || od2 !== 6'h35 || t2 !== 1'b0) begin
      n_fail++;
      $display("FAIL snarrow got v=%b d=%h t=%b exp 1 35 0",
               ov2, od2, t2);
    end
    d2 = {8'h85, 8'h00};
    v2 = 1'b1;
    tick();
    n_chk++;
    if (od2 !== E_S85 || t2 !== 1'b1) begin
      n_fail++;
      $display("FAIL s85 got d=%h t=%b exp %h 1", od2, t2, E_S85);
    end
    d2 = {8'h7F, 8'h00};
    tick();
    v2 = 1'b0;
    n_chk++;
    if (od2 !== E_S7F || t2 !== 1'b1) begin
      n_fail++;
      $display("FAIL s7f got d=%h t=%b exp %h 1", od2, t2, E_S7F);
    end
  endtask

  task automatic test_oor();
    d3 = {8'hC3, 8'h22, 8'h11};
    s3 = 2'd3;
    v3 = 1'b1;
    tick();
    n_chk++;
    if (ov3 !== 1'b1 || od3 !== 6'h00 || t3 !== 1'b0) begin
      n_fail++;
      $display("FAIL oor got v=%b d=%h t=%b exp 1 00 0",
               ov3, od3, t3);
    end
    s3 = 2'd2;
    tick();
    v3 = 1'b0;
    n_chk++;
    if (od3 !== 6'h03 || t3 !== 1'b1) begin
      n_fail++;
      $display("FAIL ch2 got d=%h t=%b exp 03 1", od3, t3);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got[$];
    logic [5:0] exp_q[3];
    logic       acc;
    exp_q[0] = 6'h01;
    exp_q[1] = 6'h02;
    exp_q[2] = 6'h03;
    s0  = 1'b0;
    or0 = 1'b0;
    d0  = 16'h0001;
    v0  = 1'b1;
    tick();
    d0 = 16'h0002;
    tick();
    d0 = 16'h0003;
    n_chk++;
    if (r0 !== 1'b0 || ov0 !== 1'b1 || od0 !== 6'h01) begin
      n_fail++;
      $display("FAIL full got r=%b v=%b d=%h exp 0 1 01",
               r0, ov0, od0);
    end
    tick();
    n_chk++;
    if (r0 !== 1'b0 || od0 !== 6'h01) begin
      n_fail++;
      $display("FAIL stall got r=%b d=%h exp 0 01", r0, od0);
    end
    or0 = 1'b1;
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      if (ov0 && or0) got.push_back(od0);
      acc = v0 && r0;
      tick();
      if (acc) v0 = 1'b0;
    end
    v0 = 1'b0;
    n_chk++;
    if (got.size() !== 3) begin
      n_fail++;
      $display("FAIL drain_count got %0d exp 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL order[%0d] got %h exp %h", i, got[i], exp_q[i]);
      end
    end
    n_chk++;
    if (ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL drained got v=%b exp 0", ov0);
    end
  endtask

  task automatic test_reset_mid();
    or0 = 1'b0;
    d0  = 16'h00AA;
    s0  = 1'b0;
    v0  = 1'b1;
    tick();
    tick();
    v0 = 1'b0;
    n_chk++;
    if (r0 !== 1'b0 || t0 !== 1'b1) begin
      n_fail++;
      $display("FAIL prefill got r=%b t=%b exp 0 1", r0, t0);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (ov0 !== 1'b0 || od0 !== 6'h00 || t0 !== 1'b0 || r0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst got v=%b d=%h t=%b r=%b exp 0 00 0 1",
               ov0, od0, t0, r0);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    or0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (ov0 !== 1'b0 || r0 !== 1'b1) begin
        n_fail++;
        $display("FAIL post_rst[%0d] got v=%b r=%b exp 0 1",
                 i, ov0, r0);
      end
    end
    d0 = 16'h0015;
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    n_chk++;
    if (ov0 !== 1'b1 || od0 !== 6'h15) begin
      n_fail++;
      $display("FAIL post_acc got v=%b d=%h exp 1 15", ov0, od0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_noloss();
    test_signed();
    test_oor();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
